// File: rtl/cmd_sender.sv
//==============================================================================
// Module   : cmd_sender
// Purpose  : Serializes a 16-bit command word onto a UART TX line as two
//            8N1 frames, high byte first, with no gap between the frames.
//            Contains its own baud generator, bit/byte sequencing and a
//            completion handshake.
// Ports    : clk       - operational clock, all logic on posedge
//            rst       - synchronous active-high reset
//            cmd       - command word, sampled on an accepted snd_cmd
//            snd_cmd   - transmit request, accepted only while idle
//            TX        - serial output, idle high (registered)
//            busy      - high while a command is being transmitted
//            cmd_sent  - level, set when both bytes are out, cleared on the
//                        next accepted request or on reset
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cmd_sender #(
    parameter int BAUD_DIV = 2604       // clk cycles per UART bit, 4..4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        TX,
    output logic        busy,
    output logic        cmd_sent
);

    localparam logic [1:0]  c_st_idle   = 2'd0;
    localparam logic [1:0]  c_st_tx_hi  = 2'd1;
    localparam logic [1:0]  c_st_tx_lo  = 2'd2;
    localparam logic [11:0] c_baud_last = 12'(BAUD_DIV - 1);
    localparam logic [3:0]  c_bit_last  = 4'd9;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [11:0] r_baud;
    logic [3:0]  r_bit;
    // Holds the bits still to be sent after the one currently on TX:
    // eight data bits followed by the stop bit. TX itself is r_tx.
    logic [8:0]  r_shift;
    // Only the low byte needs holding; the high byte goes straight into
    // the shifter on the accepting edge.
    logic [7:0]  r_hold_lo;
    logic        r_tx;
    logic        r_busy;
    logic        r_sent;

    logic        w_accept;
    logic        w_tick;
    logic        w_byte_end;
    logic        w_load_lo;
    logic        w_done;

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (snd_cmd)    w_state_nxt = c_st_tx_hi;
            c_st_tx_hi: if (w_byte_end) w_state_nxt = c_st_tx_lo;
            c_st_tx_lo: if (w_byte_end) w_state_nxt = c_st_idle;
            default:                    w_state_nxt = c_st_idle;
        endcase
    end

    //--------------------------------------------------------------------------
    // Control strobes derived from state and counters
    //--------------------------------------------------------------------------
    always_comb begin
        w_accept   = (r_state == c_st_idle) && snd_cmd;
        w_tick     = (r_state != c_st_idle) && (r_baud == c_baud_last);
        w_byte_end = w_tick && (r_bit == c_bit_last);
        w_load_lo  = (r_state == c_st_tx_hi) && w_byte_end;
        w_done     = (r_state == c_st_tx_lo) && w_byte_end;
    end

    //--------------------------------------------------------------------------
    // Datapath and registered outputs
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud    <= 12'd0;
            r_bit     <= 4'd0;
            r_shift   <= 9'd0;
            r_hold_lo <= 8'd0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_sent    <= 1'b0;
        end else begin
            // Baud counter parks at zero while idle so every frame starts
            // with a full-width start bit.
            if ((r_state == c_st_idle) || w_tick) begin
                r_baud <= 12'd0;
            end else begin
                r_baud <= r_baud + 12'd1;
            end

            if (w_tick) begin
                r_bit <= w_byte_end ? 4'd0 : (r_bit + 4'd1);
            end

            if (w_accept) begin
                r_hold_lo <= cmd[7:0];
                r_shift   <= {1'b1, cmd[15:8]};
                r_tx      <= 1'b0;                 // high-byte start bit
                r_busy    <= 1'b1;
                r_sent    <= 1'b0;
            end else if (w_load_lo) begin
                // Stop bit of the high byte ends; low-byte start bit follows
                // immediately with no idle gap.
                r_shift   <= {1'b1, r_hold_lo};
                r_tx      <= 1'b0;
            end else if (w_done) begin
                r_tx      <= 1'b1;
                r_busy    <= 1'b0;
                r_sent    <= 1'b1;
            end else if (w_tick) begin
                r_tx      <= r_shift[0];
                r_shift   <= {1'b1, r_shift[8:1]};
            end
        end
    end

    assign TX       = r_tx;
    assign busy     = r_busy;
    assign cmd_sent = r_sent;

endmodule

`default_nettype wire
